// File: rtl/clock_tree_gen.sv
// clock_tree_gen
//   Prescales GlobalClock into a slow Tick, then drives NR_OF_CHANNELS derived
//   clocks with runtime-programmable high/low tick counts. A run/step
//   controller lets the core free-run, freeze, or single-step one channel-0
//   period per Step press.
//
//   Optional feature macro: CLOCK_TREE_GEN_DEBOUNCE_EN
//     defined   -> synchronised Run/Step pass a 4-tick debouncer
//     undefined -> synchronised levels feed the state machine directly
//
// Ports:
//   GlobalClock  in   board clock, rising edge
//   nRST         in   asynchronous active-low reset
//   Run          in   1 = free-run, 0 = step mode (async pin)
//   Step         in   each rising edge requests one step (async pin)
//   HighTicks    in   per-channel high duration, channel k at [k*CNT_BITS +: CNT_BITS]
//   LowTicks     in   per-channel low duration, same packing
//   ClkOut       out  derived clock levels
//   PosEdge      out  1-cycle strobe aligned with ClkOut[k] rising
//   NegEdge      out  1-cycle strobe aligned with ClkOut[k] falling
//   Tick         out  prescaler strobe, always running
//   Running      out  1 while channels advance (RUN or STEP)
//   CycleCount   out  channel-0 rising edge count, wraps
module clock_tree_gen #(
  parameter int NR_OF_CHANNELS = 2,
  parameter int TICK_BITS      = 32,
  parameter int RELOAD_VALUE   = 1500000,
  parameter int CNT_BITS       = 8
) (
  input  logic                               GlobalClock,
  input  logic                               nRST,
  input  logic                               Run,
  input  logic                               Step,
  input  logic [NR_OF_CHANNELS*CNT_BITS-1:0] HighTicks,
  input  logic [NR_OF_CHANNELS*CNT_BITS-1:0] LowTicks,
  output logic [NR_OF_CHANNELS-1:0]          ClkOut,
  output logic [NR_OF_CHANNELS-1:0]          PosEdge,
  output logic [NR_OF_CHANNELS-1:0]          NegEdge,
  output logic                               Tick,
  output logic                               Running,
  output logic [15:0]                        CycleCount
);

  localparam logic [TICK_BITS-1:0] RELOAD_M1 = TICK_BITS'(RELOAD_VALUE - 1);
  localparam logic [TICK_BITS-1:0] TICK_ONE  = TICK_BITS'(1);
  localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

  // Prescaler
  logic [TICK_BITS-1:0] presc_q, presc_d;
  logic                 tick;

  assign tick    = (presc_q == '0);
  assign presc_d = tick ? RELOAD_M1 : presc_q - TICK_ONE;

  // Input synchronisers and step edge detect
  logic [1:0] run_sync_q, step_sync_q;
  logic       run_lvl, step_lvl, step_prev_q, step_edge;

  always_ff @(posedge GlobalClock or negedge nRST) begin
    if (!nRST) begin
      run_sync_q  <= 2'b00;
      step_sync_q <= 2'b00;
      step_prev_q <= 1'b0;
    end else begin
      run_sync_q  <= {run_sync_q[0], Run};
      step_sync_q <= {step_sync_q[0], Step};
      step_prev_q <= step_lvl;
    end
  end

`ifdef CLOCK_TREE_GEN_DEBOUNCE_EN
  logic [1:0] db_raw, db_lvl;
  assign db_raw = {step_sync_q[1], run_sync_q[1]};

  // Each level only follows its input after 4 consecutive ticks of disagreement;
  // any cycle of agreement restarts the count.
  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    logic [1:0] cnt_q;
    logic       lvl_q;
    always_ff @(posedge GlobalClock or negedge nRST) begin
      if (!nRST) begin
        cnt_q <= 2'd0;
        lvl_q <= 1'b0;
      end else if (db_raw[gi] == lvl_q) begin
        cnt_q <= 2'd0;
      end else if (tick) begin
        if (cnt_q == 2'd3) begin
          lvl_q <= db_raw[gi];
          cnt_q <= 2'd0;
        end else begin
          cnt_q <= cnt_q + 2'd1;
        end
      end
    end
    assign db_lvl[gi] = lvl_q;
  end

  assign run_lvl  = db_lvl[0];
  assign step_lvl = db_lvl[1];
`else
  assign run_lvl  = run_sync_q[1];
  assign step_lvl = step_sync_q[1];
`endif

  assign step_edge = step_lvl && !step_prev_q;

  // Channels
  logic                               running_q, advance, fall0;
  logic [NR_OF_CHANNELS*CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NR_OF_CHANNELS-1:0]          phase_q, phase_d, pos_q, pos_d, neg_q, neg_d, toggle;
  logic [15:0]                        cycle_q;

  assign advance = tick && running_q;

  for (genvar gi = 0; gi < NR_OF_CHANNELS; gi++) begin : g_ch
    logic [CNT_BITS-1:0] cur, len, load;
    assign cur = cnt_q[gi*CNT_BITS +: CNT_BITS];
    // Length of the phase being entered: currently high -> going low.
    assign len = phase_q[gi] ? LowTicks[gi*CNT_BITS +: CNT_BITS]
                             : HighTicks[gi*CNT_BITS +: CNT_BITS];
    // A programmed 0 behaves like 1.
    assign load       = (len == '0) ? '0 : len - CNT_ONE;
    assign toggle[gi] = advance && (cur == '0);
    assign cnt_d[gi*CNT_BITS +: CNT_BITS] = !advance   ? cur  :
                                            toggle[gi] ? load : cur - CNT_ONE;
    assign phase_d[gi] = phase_q[gi] ^ toggle[gi];
    assign pos_d[gi]   = toggle[gi] && !phase_q[gi];
    assign neg_d[gi]   = toggle[gi] && phase_q[gi];
  end

  assign fall0 = toggle[0] && phase_q[0];

  always_ff @(posedge GlobalClock or negedge nRST) begin
    if (!nRST) begin
      presc_q <= RELOAD_M1;
      cnt_q   <= '0;
      phase_q <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      cycle_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      if (pos_d[0]) cycle_q <= cycle_q + 16'd1;
    end
  end

  // Run/step controller; Running is registered alongside the state.
  state_t state_q;

  always_ff @(posedge GlobalClock or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_lvl) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end else if (step_edge) begin
            state_q   <= S_STEP;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (!run_lvl) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        end
        S_STEP: begin
          if (run_lvl) begin
            state_q   <= S_RUN;
          end else if (fall0) begin
            // Leave on the same edge that drops ClkOut[0].
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign ClkOut     = phase_q;
  assign PosEdge    = pos_q;
  assign NegEdge    = neg_q;
  assign Tick       = tick;
  assign Running    = running_q;
  assign CycleCount = cycle_q;

endmodule

// File: tb/tb_clock_tree_gen.sv
// Directed testbench for clock_tree_gen with RELOAD_VALUE=4 and two channels.
module tb_clock_tree_gen;

  logic        clk;
  logic        nrst;
  logic        run;
  logic        step;
  logic [15:0] high_ticks;
  logic [15:0] low_ticks;
  logic [1:0]  clk_out, pos_edge, neg_edge;
  logic        tick, running;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  clock_tree_gen #(
    .NR_OF_CHANNELS(2),
    .TICK_BITS(8),
    .RELOAD_VALUE(4),
    .CNT_BITS(8)
  ) dut (
    .GlobalClock(clk),
    .nRST(nrst),
    .Run(run),
    .Step(step),
    .HighTicks(high_ticks),
    .LowTicks(low_ticks),
    .ClkOut(clk_out),
    .PosEdge(pos_edge),
    .NegEdge(neg_edge),
    .Tick(tick),
    .Running(running),
    .CycleCount(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance from one falling edge to the falling edge n cycles later.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Move to the next cycle in which Tick and Running are both high.
  task automatic wait_adv();
    int k;
    k = 0;
    while (!(tick && running) && k < 40) begin
      cyc(1);
      k++;
    end
    check("adv_wait", 32'(tick && running), 32'd1);
  endtask

  task automatic wait_running(input logic v, input int limit);
    int k;
    k = 0;
    while (running !== v && k < limit) begin
      cyc(1);
      k++;
    end
    check("running_wait", 32'(running), 32'(v));
  endtask

  task automatic do_reset(input logic run_v);
    nrst = 1'b0;
    run  = run_v;
    step = 1'b0;
    cyc(2);
    nrst = 1'b1;
  endtask

  initial begin
    logic        exp_lvl;
    logic        e0, e1;
    logic [10:0] pat;

    nrst       = 1'b0;
    run        = 1'b0;
    step       = 1'b0;
    high_ticks = 16'h0101;
    low_ticks  = 16'h0101;

    // Reset state
    @(negedge clk);
    $display("step: reset state");
    check("rst_clkout",  32'(clk_out),     32'd0);
    check("rst_posedge", 32'(pos_edge),    32'd0);
    check("rst_negedge", 32'(neg_edge),    32'd0);
    check("rst_tick",    32'(tick),        32'd0);
    check("rst_running", 32'(running),     32'd0);
    check("rst_cycles",  32'(cycle_count), 32'd0);
    cyc(1);

`ifndef CLOCK_TREE_GEN_DEBOUNCE_EN
    // Free run, H=L=1: toggle on every tick, 4-cycle tick period
    $display("step: free run H=L=1");
    do_reset(1'b1);
    wait_adv();
    exp_lvl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_lvl = ~exp_lvl;
      cyc(1);
      check("fr_clkout",  32'(clk_out),  exp_lvl ? 32'd3 : 32'd0);
      check("fr_posedge", 32'(pos_edge), exp_lvl ? 32'd3 : 32'd0);
      check("fr_negedge", 32'(neg_edge), exp_lvl ? 32'd0 : 32'd3);
      check("fr_tick_lo", 32'(tick),     32'd0);
      cyc(1);
      check("fr_strobe_w", 32'({pos_edge, neg_edge}), 32'd0);
      cyc(2);
      check("fr_tick_period", 32'(tick && running), 32'd1);
    end
    check("fr_cycles", 32'(cycle_count), 32'd3);

    // Two channels: ch0 H=2/L=3, ch1 H=1/L=1 for 40 ticks
    $display("step: two channels 40 ticks");
    high_ticks = 16'h0102;
    low_ticks  = 16'h0103;
    do_reset(1'b1);
    for (int i = 1; i <= 40; i++) begin
      wait_adv();
      cyc(1);
      e0 = ((i - 1) % 5) < 2;
      e1 = (i % 2) == 1;
      check("tc_clkout", 32'(clk_out), 32'({e1, e0}));
    end
    check("tc_cycles", 32'(cycle_count), 32'd8);

    // Single step from reset, second Step press ignored
    $display("step: single step");
    do_reset(1'b0);
    step = 1'b1;
    cyc(2);
    check("st_latency_early", 32'(running), 32'd0);
    cyc(1);
    check("st_latency", 32'(running), 32'd1);
    wait_adv();
    cyc(1);
    check("st_rise_clk",  32'(clk_out),     32'd3);
    check("st_rise_pos",  32'(pos_edge),    32'd3);
    check("st_rise_cnt",  32'(cycle_count), 32'd1);
    step = 1'b0;
    wait_adv();
    cyc(1);
    check("st_hold_clk", 32'(clk_out), 32'd1);
    check("st_hold_run", 32'(running), 32'd1);
    step = 1'b1;
    wait_adv();
    cyc(1);
    check("st_fall_run", 32'(running),  32'd0);
    check("st_fall_clk", 32'(clk_out),  32'd2);
    check("st_fall_neg", 32'(neg_edge), 32'd1);
    check("st_fall_pos", 32'(pos_edge), 32'd2);
    cyc(30);
    check("st_idle_run", 32'(running),     32'd0);
    check("st_idle_clk", 32'(clk_out),     32'd2);
    check("st_idle_cnt", 32'(cycle_count), 32'd1);
    step = 1'b0;

    // Freeze mid-high and resume without restart
    $display("step: freeze and resume");
    high_ticks = 16'h0103;
    low_ticks  = 16'h0103;
    do_reset(1'b1);
    wait_adv();
    cyc(1);
    check("fz_rise", 32'(clk_out[0]), 32'd1);
    wait_adv();
    cyc(1);
    check("fz_high", 32'(clk_out[0]), 32'd1);
    run = 1'b0;
    cyc(3);
    check("fz_running", 32'(running), 32'd0);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      check("fz_hold", 32'({clk_out[0], pos_edge[0], neg_edge[0]}), 32'b100);
    end
    check("fz_cycles", 32'(cycle_count), 32'd1);
    run = 1'b1;
    wait_adv();
    cyc(1);
    check("fz_resume_clk", 32'(clk_out[0]),  32'd1);
    check("fz_resume_neg", 32'(neg_edge[0]), 32'd0);
    wait_adv();
    cyc(1);
    check("fz_fall_clk", 32'(clk_out[0]),  32'd0);
    check("fz_fall_neg", 32'(neg_edge[0]), 32'd1);

    // HighTicks changes mid-phase take effect at the next toggle; 0 acts as 1
    $display("step: high ticks reprogramming");
    high_ticks = 16'h0102;
    low_ticks  = 16'h0101;
    pat        = 11'b01011111011;
    do_reset(1'b1);
    for (int i = 0; i < 11; i++) begin
      wait_adv();
      cyc(1);
      check("hp_clkout", 32'(clk_out[0]), 32'(pat[i]));
      if (i == 0) high_ticks[7:0] = 8'd5;
      if (i == 3) high_ticks[7:0] = 8'd0;
    end

    // Asynchronous reset in the middle of a step
    $display("step: reset mid-step");
    high_ticks = 16'h0103;
    low_ticks  = 16'h0103;
    do_reset(1'b0);
    step = 1'b1;
    wait_running(1'b1, 10);
    wait_adv();
    cyc(1);
    check("rs_pre_clk", 32'(clk_out[0]),  32'd1);
    check("rs_pre_cnt", 32'(cycle_count), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("rs_clkout",  32'(clk_out),     32'd0);
    check("rs_posedge", 32'(pos_edge),    32'd0);
    check("rs_negedge", 32'(neg_edge),    32'd0);
    check("rs_tick",    32'(tick),        32'd0);
    check("rs_running", 32'(running),     32'd0);
    check("rs_cycles",  32'(cycle_count), 32'd0);
    step = 1'b0;
    @(negedge clk);
    cyc(3);
    nrst = 1'b1;
    cyc(20);
    check("rs_idle_run", 32'(running),     32'd0);
    check("rs_idle_clk", 32'(clk_out),     32'd0);
    check("rs_idle_cnt", 32'(cycle_count), 32'd0);
`else
    // Debounce: a 2-tick Step glitch is dropped, a stable press steps once
    $display("step: debounce glitch");
    high_ticks = 16'h0103;
    low_ticks  = 16'h0103;
    do_reset(1'b0);
    step = 1'b1;
    cyc(8);
    step = 1'b0;
    cyc(60);
    check("db_glitch_run", 32'(running),     32'd0);
    check("db_glitch_cnt", 32'(cycle_count), 32'd0);
    check("db_glitch_clk", 32'(clk_out),     32'd0);
    $display("step: debounce stable press");
    step = 1'b1;
    wait_running(1'b1, 40);
    wait_running(1'b0, 100);
    check("db_step_cnt", 32'(cycle_count), 32'd1);
    check("db_step_clk", 32'(clk_out[0]),  32'd0);
    cyc(40);
    step = 1'b0;
    cyc(60);
    check("db_once_run", 32'(running),     32'd0);
    check("db_once_cnt", 32'(cycle_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
